// File: rtl/conv1_window_gen.sv
// conv1_window_gen
//   Producer side of the conv1 3x3 window bus. Takes a raster-order pixel
//   stream and emits 9-tap windows for valid ("no padding") convolution.
//   A frame of IMG_W x IMG_H pixels yields (IMG_W-2)*(IMG_H-2) windows.
//   Two line buffers hold the previous two rows. A 3x3 shift array holds the
//   last three columns.
//
// Ports
//   clk, rst     single rising-edge clock, asynchronous active-high reset
//   in_data      pixel word, raster order
//   in_valid     in_data valid
//   in_ready     block can accept a pixel this cycle
//   data_out     window, index 3*dr+dc; [0] = pixel (r-2,c-2), [8] = pixel (r,c)
//   win_valid    data_out holds a window
//   win_ready    consumer takes the window this cycle
//   frame_done   one-cycle pulse, the cycle after the last pixel of a frame
//   win_cnt      (only with CONV1_WIN_CNT_EN) windows handshaken this frame
//   dbg_state    current FSM state (0 = FILL, 1 = RUN)
//
// Handshake semantics (both sides):
//   - A transfer happens on a rising edge where valid && ready.
//   - valid, once high, stays high with stable data until that transfer.
//   - in_ready depends only on win_valid/win_ready, never on in_valid.
//
// Optional feature macro: CONV1_WIN_CNT_EN (adds the win_cnt output).
module conv1_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [0:8][DATA_W-1:0] data_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   frame_done,
`ifdef CONV1_WIN_CNT_EN
    output logic [15:0]            win_cnt,
`endif
    output logic                   dbg_state
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [0:8][DATA_W-1:0]  win_q, win_d;
    logic [0:8][DATA_W-1:0]  data_out_q, data_out_d;
    logic                    win_valid_q, win_valid_d;
    logic                    frame_done_q;
    logic [DATA_W-1:0]       lb0_q [IMG_W];
    logic [DATA_W-1:0]       lb1_q [IMG_W];

    logic accept, col_last, row_last, frame_last, issue;

    assign in_ready   = !win_valid_q || win_ready;
    assign accept     = in_valid && in_ready;
    assign col_last   = (col_q == CW'(IMG_W - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));
    assign frame_last = accept && col_last && row_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: if (accept && col_last && (row_q == RW'(1))) state_d = S_RUN;
            S_RUN:  if (frame_last)                             state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A window only issues in RUN, so line-buffer contents left over from the
    // previous frame (or from before a reset) are never emitted.
    always_comb begin
        issue     = accept && (state_q == S_RUN) && (col_q >= CW'(2));
        dbg_state = state_q;
    end

    // ---------------- raster counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // ---------------- window shift / output hold ----------------
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb1_q[col_q];
            win_d[5] = lb0_q[col_q];
            win_d[8] = in_data;
        end
        data_out_d  = issue ? win_d : data_out_q;
        // A new window loaded in the same cycle as a handshake keeps valid high.
        if (issue)                          win_valid_d = 1'b1;
        else if (win_valid_q && win_ready)  win_valid_d = 1'b0;
        else                                win_valid_d = win_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            data_out_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            data_out_q   <= data_out_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_last;
        end
    end

    // Line buffers: storage only, no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_data;
        end
    end

    assign data_out   = data_out_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef CONV1_WIN_CNT_EN
    logic [15:0] win_cnt_q;
    // Clearing on the first pixel takes priority: any handshake in that cycle
    // belongs to the previous frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win_cnt_q <= '0;
        else if (accept && (col_q == '0) && (row_q == '0))
            win_cnt_q <= '0;
        else if (win_valid_q && win_ready && (win_cnt_q != 16'hFFFF))
            win_cnt_q <= win_cnt_q + 16'd1;
    end
    assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv1_window_gen.sv
module tb_conv1_window_gen;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int DATA_W = 32;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int WW     = 9 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [0:8][DATA_W-1:0] data_out;
  logic                   win_valid;
  logic                   win_ready;
  logic                   frame_done;
  logic                   dbg_state;
`ifdef CONV1_WIN_CNT_EN
  logic [15:0]            win_cnt;
`endif

  conv1_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done),
`ifdef CONV1_WIN_CNT_EN
    .win_cnt    (win_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WW-1:0]     exp_q[$];
  logic [DATA_W-1:0] pix [NPIX];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_win  = 0;
  int n_done = 0;
  int last_issue_cyc = -10;
  int last_frame_cyc = -10;
  logic prev_wv = 1'b0;
  logic t5_done;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_wv = 1'b0;
    end else begin
      if (win_valid && !prev_wv)
        check("win_latency", WW'(cyc), WW'(last_issue_cyc + 1));
      if (frame_done) begin
        n_done++;
        check("done_latency", WW'(cyc), WW'(last_frame_cyc + 1));
        check("done_with_win", WW'(win_valid), WW'(1));
      end
      if (win_valid && win_ready) begin
        n_win++;
        if (exp_q.size() == 0) check("unexpected_win", WW'(exp_q.size()), WW'(1));
        else                   check("win_data", data_out, exp_q.pop_front());
      end
      prev_wv = win_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input int k, input logic [DATA_W-1:0] v);
    logic acc;
    int n;
    int r;
    int c;
    logic [0:8][DATA_W-1:0] w;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept_timeout", WW'(acc), WW'(1));
    if (acc) begin
      r = k / IMG_W;
      c = k % IMG_W;
      pix[k] = v;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 9; i++)
          w[i] = pix[(r - 2 + i / 3) * IMG_W + (c - 2 + i % 3)];
        exp_q.push_back(w);
        last_issue_cyc = cyc - 1;
      end
      if (k == NPIX - 1) last_frame_cyc = cyc - 1;
`ifdef CONV1_WIN_CNT_EN
      if (k == 0) check("win_cnt_clear", WW'(win_cnt), WW'(0));
`endif
    end
  endtask

  task automatic send_frame(input int base, input int gap_pct);
    for (int k = 0; k < NPIX; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct)
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      send_pixel(k, DATA_W'(base + k));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || win_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", WW'(exp_q.size()), WW'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int w0, d0, nw;
  logic [WW-1:0] snap;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; win_ready = 1'b1; t5_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_win_valid",  WW'(win_valid),  WW'(0));
    check("rst_frame_done", WW'(frame_done), WW'(0));
    check("rst_data_out",   data_out,        WW'(0));
    check("rst_in_ready",   WW'(in_ready),   WW'(1));
    check("rst_state",      WW'(dbg_state),  WW'(0));
    @(posedge clk); #1; rst = 1'b0;

    // single frame, consumer always ready
    w0 = n_win; d0 = n_done;
    send_frame(0, 0);
    drain();
    @(negedge clk);
    check("t1_windows", WW'(n_win - w0),  WW'(9));
    check("t1_done",    WW'(n_done - d0), WW'(1));
    check("t1_state",   WW'(dbg_state),   WW'(0));
`ifdef CONV1_WIN_CNT_EN
    check("t1_win_cnt", WW'(win_cnt), WW'(9));
`endif
    @(posedge clk); #1;

    // consumer stall right after the first window
    w0 = n_win; d0 = n_done;
    fork
      send_frame(0, 0);
      begin
        nw = 0;
        while (!win_valid && nw < 200) begin @(negedge clk); nw++; end
        check("stall_wait", WW'(win_valid), WW'(1));
        @(posedge clk); #1; win_ready = 1'b0;
        @(negedge clk);
        snap = data_out;
        check("stall_in_ready", WW'(in_ready),  WW'(0));
        check("stall_valid",    WW'(win_valid), WW'(1));
        repeat (2) begin
          @(negedge clk);
          check("stall_data_stable", data_out,      snap);
          check("stall_in_ready",    WW'(in_ready), WW'(0));
        end
        @(posedge clk); #1; win_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    check("t2_windows", WW'(n_win - w0),  WW'(9));
    check("t2_done",    WW'(n_done - d0), WW'(1));
    @(posedge clk); #1;

    // two frames back-to-back
    w0 = n_win; d0 = n_done;
    send_frame(0, 0);
    send_frame(100, 0);
    drain();
    @(negedge clk);
    check("t3_windows", WW'(n_win - w0),  WW'(18));
    check("t3_done",    WW'(n_done - d0), WW'(2));
    @(posedge clk); #1;

    // reset mid-frame
    w0 = n_win; d0 = n_done;
    for (int k = 0; k < 7; k++) send_pixel(k, DATA_W'(500 + k));
    pulse_reset();
    @(negedge clk);
    check("t4_rst_valid", WW'(win_valid), WW'(0));
    check("t4_rst_state", WW'(dbg_state), WW'(0));
    check("t4_rst_data",  data_out,       WW'(0));
    @(posedge clk); #1;
    send_frame(0, 0);
    drain();
    @(negedge clk);
    check("t4_windows", WW'(n_win - w0),  WW'(9));
    check("t4_done",    WW'(n_done - d0), WW'(1));
    @(posedge clk); #1;

    // random input gaps and random consumer back-pressure
    w0 = n_win; d0 = n_done;
    fork
      begin
        send_frame(300, 50);
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk); #1;
          win_ready = ($urandom_range(1) == 1);
        end
        win_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    check("t5_windows", WW'(n_win - w0),  WW'(9));
    check("t5_done",    WW'(n_done - d0), WW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
